// File: rtl/cordic_pkg.sv
// Shared definitions for the CORDIC sharing controller: default data width,
// the +/-90 degree range limits in Q16.16, and the scheduler state encoding.
package cordic_pkg;

    localparam int WIDTH = 32;

    localparam logic signed [31:0] ANG_P90 = 32'sd5898240;
    localparam logic signed [31:0] ANG_N90 = -32'sd5898240;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

endpackage

// File: rtl/cordic_share_ctrl_rr_pick.sv
// Combinational round-robin picker: returns the first valid index at or after
// ptr (circular), its one-hot grant, and whether anything was valid at all.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PW    = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PW-1:0]    idx,
    output logic             any
);

    function automatic logic [PW-1:0] slot_of(input logic [PW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return PW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest valid slot wins.
    always_comb begin
        logic [PW-1:0] s;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        s     = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            s = slot_of(ptr, off);
            if (valid[s]) begin
                grant    = '0;
                grant[s] = 1'b1;
                idx      = s;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cordic_share_ctrl.sv
// Round-robin scheduler sharing one CORDIC sin/cos engine among N_REQ clients:
// range-checks angles, sequences start/done, and routes results to the owner.
module cordic_share_ctrl #(
    parameter int WIDTH   = cordic_pkg::WIDTH,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_theta,
    output logic [N_REQ-1:0]       req_ready,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       rsp_sin,
    output logic [WIDTH-1:0]       rsp_cos,
    output logic                   cordic_start,
    output logic [WIDTH-1:0]       cordic_theta,
    input  logic [WIDTH-1:0]       cordic_sin,
    input  logic [WIDTH-1:0]       cordic_cos,
    input  logic                   cordic_done,
    output logic                   busy
);

    import cordic_pkg::*;

    localparam int PW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT);

    localparam logic signed [WIDTH-1:0] ANG_HI = WIDTH'(ANG_P90);
    localparam logic signed [WIDTH-1:0] ANG_LO = WIDTH'(ANG_N90);
    localparam logic [TW-1:0]           T_MAX  = TW'(TIMEOUT - 1);
    localparam logic [PW-1:0]           P_LAST = PW'(N_REQ - 1);

    state_e                   state_q, state_d;
    logic [PW-1:0]            rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]            owner_q, owner_d;
    logic signed [WIDTH-1:0]  theta_q, theta_d;
    logic signed [WIDTH-1:0]  sin_q, sin_d;
    logic signed [WIDTH-1:0]  cos_q, cos_d;
    logic                     err_q, err_d;
    logic                     done_q, done_d;
    logic [TW-1:0]            timer_q, timer_d;

    logic [N_REQ-1:0]         pick_grant;
    logic [PW-1:0]            pick_idx;
    logic                     pick_any;
    logic signed [WIDTH-1:0]  pick_theta;
    logic                     pick_bad;
    logic                     done_rise;

    rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    assign pick_theta = req_theta[int'(pick_idx)*WIDTH +: WIDTH];
    assign pick_bad   = (pick_theta > ANG_HI) || (pick_theta < ANG_LO);

    // A done level that is already high when WAIT starts must not count.
    assign done_rise  = cordic_done & ~done_q;

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        theta_d  = theta_q;
        sin_d    = sin_q;
        cos_d    = cos_q;
        err_d    = err_q;
        timer_d  = timer_q;
        done_d   = cordic_done;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_d  = pick_idx;
                    theta_d  = pick_theta;
                    rr_ptr_d = (pick_idx == P_LAST) ? '0 : pick_idx + 1'b1;
                    err_d    = pick_bad;
                    state_d  = pick_bad ? ST_RESP : ST_START;
                end
            end
            ST_START: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done_rise) begin
                    sin_d   = cordic_sin;
                    cos_d   = cordic_cos;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end else if (timer_q == T_MAX) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            theta_q  <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            timer_q  <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            theta_q  <= theta_d;
            sin_q    <= sin_d;
            cos_q    <= cos_d;
            err_q    <= err_d;
            done_q   <= done_d;
            timer_q  <= timer_d;
        end
    end

    // Grants are only offered from IDLE and never while reset is applied.
    always_comb begin
        req_ready    = '0;
        rsp_valid    = '0;
        rsp_err      = 1'b0;
        cordic_start = 1'b0;
        busy         = (state_q != ST_IDLE);
        if ((state_q == ST_IDLE) && !rst) begin
            req_ready = pick_grant;
        end
        if (state_q == ST_RESP) begin
            rsp_valid[owner_q] = 1'b1;
            rsp_err            = err_q;
        end
        if (state_q == ST_START) begin
            cordic_start = 1'b1;
        end
    end

    assign rsp_sin      = sin_q;
    assign rsp_cos      = cos_q;
    assign cordic_theta = theta_q;

endmodule

// File: tb/tb_cordic_share_ctrl.sv
// Directed bench for cordic_share_ctrl; the bench itself plays the CORDIC engine.
module tb_cordic_share_ctrl;

    localparam int WIDTH   = 32;
    localparam int N_REQ   = 4;
    localparam int TIMEOUT = 64;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ*WIDTH-1:0] req_theta;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0]       rsp_valid;
    logic                   rsp_err;
    logic [WIDTH-1:0]       rsp_sin;
    logic [WIDTH-1:0]       rsp_cos;
    logic                   cordic_start;
    logic [WIDTH-1:0]       cordic_theta;
    logic [WIDTH-1:0]       cordic_sin;
    logic [WIDTH-1:0]       cordic_cos;
    logic                   cordic_done;
    logic                   busy;

    logic [WIDTH-1:0]       theta_tab [N_REQ];
    logic [31:0]            last_sin;
    logic [31:0]            last_cos;
    int                     n_cmp = 0;
    int                     n_mis = 0;

    for (genvar g = 0; g < N_REQ; g++) begin : g_theta
        assign req_theta[g*WIDTH +: WIDTH] = theta_tab[g];
    end

    always #5 clk = ~clk;

    cordic_share_ctrl #(
        .WIDTH   (WIDTH),
        .N_REQ   (N_REQ),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_theta    (req_theta),
        .req_ready    (req_ready),
        .rsp_valid    (rsp_valid),
        .rsp_err      (rsp_err),
        .rsp_sin      (rsp_sin),
        .rsp_cos      (rsp_cos),
        .cordic_start (cordic_start),
        .cordic_theta (cordic_theta),
        .cordic_sin   (cordic_sin),
        .cordic_cos   (cordic_cos),
        .cordic_done  (cordic_done),
        .busy         (busy)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_reset(input string tag);
        check_eq({tag, "_ready"}, 32'(req_ready), 32'd0);
        check_eq({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_err"}, 32'(rsp_err), 32'd0);
        check_eq({tag, "_sin"}, rsp_sin, 32'd0);
        check_eq({tag, "_cos"}, rsp_cos, 32'd0);
        check_eq({tag, "_start"}, 32'(cordic_start), 32'd0);
        check_eq({tag, "_theta"}, cordic_theta, 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // One in-range operation: grant to who, engine done dly cycles after start.
    task automatic do_op(input string tag, input logic [N_REQ-1:0] vmask, input int who,
                         input int dly, input logic [31:0] s, input logic [31:0] c);
        logic [N_REQ-1:0] oh;
        int starts;
        int rsps;
        oh      = '0;
        oh[who] = 1'b1;
        req_valid = vmask;
        #1;
        check_eq({tag, "_grant"}, 32'(req_ready), 32'(oh));
        step();
        req_valid = vmask & ~oh;
        #1;
        check_eq({tag, "_start"}, 32'(cordic_start), 32'd1);
        check_eq({tag, "_theta"}, cordic_theta, theta_tab[who]);
        check_eq({tag, "_noready"}, 32'(req_ready), 32'd0);
        starts = 1;
        rsps   = 0;
        for (int i = 0; i < dly; i++) begin
            step();
            if (cordic_start) starts++;
            if (rsp_valid != '0) rsps++;
        end
        cordic_sin  = s;
        cordic_cos  = c;
        cordic_done = 1'b1;
        step();
        check_eq({tag, "_rspv"}, 32'(rsp_valid), 32'(oh));
        check_eq({tag, "_err"}, 32'(rsp_err), 32'd0);
        check_eq({tag, "_sin"}, rsp_sin, s);
        check_eq({tag, "_cos"}, rsp_cos, c);
        check_eq({tag, "_nstart"}, 32'(starts), 32'd1);
        check_eq({tag, "_early"}, 32'(rsps), 32'd0);
        last_sin    = s;
        last_cos    = c;
        cordic_done = 1'b0;
        cordic_sin  = '0;
        cordic_cos  = '0;
        step();
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_rspoff"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_hold"}, rsp_sin, s);
    endtask

    // Out-of-range request: no engine start, error response one cycle after accept.
    task automatic err_op(input string tag, input logic [N_REQ-1:0] vmask, input int who);
        logic [N_REQ-1:0] oh;
        oh      = '0;
        oh[who] = 1'b1;
        req_valid = vmask;
        #1;
        check_eq({tag, "_grant"}, 32'(req_ready), 32'(oh));
        step();
        req_valid = '0;
        #1;
        check_eq({tag, "_rspv"}, 32'(rsp_valid), 32'(oh));
        check_eq({tag, "_err"}, 32'(rsp_err), 32'd1);
        check_eq({tag, "_nostart"}, 32'(cordic_start), 32'd0);
        check_eq({tag, "_sin"}, rsp_sin, last_sin);
        step();
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
        check_eq({tag, "_rspoff"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int n;
        int rsps;
        rst         = 1'b1;
        req_valid   = '0;
        cordic_sin  = '0;
        cordic_cos  = '0;
        cordic_done = 1'b0;
        last_sin    = '0;
        last_cos    = '0;
        for (int i = 0; i < N_REQ; i++) theta_tab[i] = '0;
        step();
        step();
        check_idle_reset("rst");
        rst = 1'b0;

        // 1: single request, 30 degrees, engine done 20 cycles after start
        theta_tab[0] = 32'd1966080;
        do_op("t1", 4'b0001, 0, 20, 32'h0000_8000, 32'h0000_DDB4);

        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        check_eq("rst2_busy", 32'(busy), 32'd0);

        // 2: all four valid, ptr=0 -> 0,1,2,3; then req3+req0 -> 0 before 3
        theta_tab[0] = 32'd1000;
        theta_tab[1] = 32'd2000;
        theta_tab[2] = -32'd3000;
        theta_tab[3] = 32'd4000;
        do_op("t2a", 4'b1111, 0, 3, 32'h0000_1111, 32'h0000_2222);
        do_op("t2b", 4'b1110, 1, 2, 32'h0000_3333, 32'h0000_4444);
        do_op("t2c", 4'b1100, 2, 4, 32'hFFFF_5555, 32'h0000_6666);
        do_op("t2d", 4'b1000, 3, 1, 32'h0000_7777, 32'h0000_8888);
        do_op("t2e", 4'b1001, 0, 2, 32'h0000_0101, 32'h0000_0202);
        do_op("t2f", 4'b1000, 3, 2, 32'h0000_0303, 32'h0000_0404);

        // 3: range boundaries (ptr now 0)
        theta_tab[1] = 32'd5898241;
        err_op("t3a", 4'b0010, 1);
        theta_tab[2] = -32'd5898240;
        do_op("t3b", 4'b0100, 2, 5, 32'hFFFF_0000, 32'h0000_0000);
        theta_tab[3] = 32'd5898240;
        do_op("t3c", 4'b1000, 3, 3, 32'h0001_0000, 32'h0000_0000);
        theta_tab[0] = -32'd5898241;
        err_op("t3d", 4'b0001, 0);

        // 4: done already high on WAIT entry; real edge 15 cycles after start (ptr 1)
        theta_tab[1] = 32'd2949120;
        cordic_done  = 1'b1;
        req_valid    = 4'b0010;
        #1;
        check_eq("t4_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        #1;
        check_eq("t4_start", 32'(cordic_start), 32'd1);
        rsps = 0;
        for (int i = 0; i < 15; i++) begin
            step();
            if (rsp_valid != '0) rsps++;
            if (i >= 5) cordic_done = 1'b0;
        end
        check_eq("t4_early", 32'(rsps), 32'd0);
        check_eq("t4_busy", 32'(busy), 32'd1);
        cordic_sin  = 32'h0000_B505;
        cordic_cos  = 32'h0000_B505;
        cordic_done = 1'b1;
        step();
        check_eq("t4_rspv", 32'(rsp_valid), 32'b0010);
        check_eq("t4_err", 32'(rsp_err), 32'd0);
        check_eq("t4_sin", rsp_sin, 32'h0000_B505);
        last_sin    = 32'h0000_B505;
        last_cos    = 32'h0000_B505;
        cordic_done = 1'b0;
        step();
        check_eq("t4_idle", 32'(busy), 32'd0);

        // 5: engine never completes -> timeout error (ptr 2, only req0 valid)
        theta_tab[0] = 32'd100;
        req_valid    = 4'b0001;
        #1;
        check_eq("t5_grant", 32'(req_ready), 32'b0001);
        step();
        req_valid = '0;
        #1;
        check_eq("t5_start", 32'(cordic_start), 32'd1);
        step();
        n = 0;
        while (rsp_valid == '0 && n < 200) begin
            step();
            n++;
        end
        check_eq("t5_cycles", 32'(n), 32'(TIMEOUT));
        check_eq("t5_rspv", 32'(rsp_valid), 32'b0001);
        check_eq("t5_err", 32'(rsp_err), 32'd1);
        check_eq("t5_sin", rsp_sin, last_sin);
        check_eq("t5_cos", rsp_cos, last_cos);
        step();
        check_eq("t5_idle", 32'(busy), 32'd0);
        check_eq("t5_rspoff", 32'(rsp_valid), 32'd0);

        // 6: reset during WAIT (ptr 1 -> grant 2, ptr becomes 3 before reset)
        theta_tab[2] = 32'd123456;
        req_valid    = 4'b0100;
        #1;
        check_eq("t6_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();
        step();
        step();
        check_eq("t6_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        check_idle_reset("t6rst");
        rst         = 1'b0;
        cordic_sin  = 32'h0000_1234;
        cordic_done = 1'b1;
        rsps = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rsp_valid != '0) rsps++;
        end
        check_eq("t6_lost", 32'(rsps), 32'd0);
        check_eq("t6_sin", rsp_sin, 32'd0);
        cordic_done = 1'b0;
        req_valid   = 4'b1111;
        #1;
        check_eq("t6_ptr0", 32'(req_ready), 32'b0001);
        req_valid = '0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
